// File: rtl/auth_table.sv
// UID authorisation table: check/add/remove/clear of variable-length UIDs,
// one entry examined per cycle so every scanned command has fixed latency.
module auth_table #(
  parameter  int unsigned UID_MAX     = 8,
  parameter  int unsigned UID_LEN_MAX = 10,
  localparam int unsigned IDXW        = $clog2(UID_MAX),
  localparam int unsigned CNTW        = $clog2(UID_MAX + 1),
  localparam int unsigned UIDW        = 8 * UID_LEN_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [7:0]      req_cmd,
  input  logic [UIDW-1:0] req_uid,
  input  logic [7:0]      req_uid_len,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2:0]      rsp_status,
  output logic [IDXW-1:0] rsp_index,
  output logic [CNTW-1:0] uid_count
);

  localparam int unsigned LENW = 8;

  localparam logic [7:0] CMD_CHECK  = 8'h10;
  localparam logic [7:0] CMD_ADD    = 8'h11;
  localparam logic [7:0] CMD_REMOVE = 8'h12;
  localparam logic [7:0] CMD_CLEAR  = 8'h13;

  localparam logic [2:0] ST_OK        = 3'd0;
  localparam logic [2:0] ST_NOT_FOUND = 3'd1;
  localparam logic [2:0] ST_DUPLICATE = 3'd2;
  localparam logic [2:0] ST_FULL      = 3'd3;
  localparam logic [2:0] ST_BAD_LEN   = 3'd4;
  localparam logic [2:0] ST_BAD_CMD   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // table storage
  logic            tbl_valid [UID_MAX];
  logic [LENW-1:0] tbl_len   [UID_MAX];
  logic [UIDW-1:0] tbl_data  [UID_MAX];

  // latched request and scan bookkeeping
  logic [7:0]      lat_cmd;
  logic [LENW-1:0] lat_len;
  logic [UIDW-1:0] lat_uid;
  logic [IDXW-1:0] scan_idx;
  logic            hit_found, free_found;
  logic [IDXW-1:0] hit_idx, free_idx;

  // registered outputs and their next values
  logic            req_ready_d, rsp_valid_d;
  logic [2:0]      rsp_status_d;
  logic [IDXW-1:0] rsp_index_d;
  logic [CNTW-1:0] uid_count_d;

  // table write controls
  logic            latch_en, wr_add, wr_rem, wr_clr;
  logic [IDXW-1:0] wr_idx;

  logic [UIDW-1:0] uid_masked;
  logic            cur_hit, cur_free, fin_hit, fin_free, scan_last;
  logic [IDXW-1:0] fin_hit_idx, fin_free_idx;

  // zero every byte at or beyond the requested length so stored data compares whole
  always_comb begin
    uid_masked = '0;
    for (int j = 0; j < int'(UID_LEN_MAX); j++) begin
      if (LENW'(j) < req_uid_len) uid_masked[8*j +: 8] = req_uid[8*j +: 8];
    end
  end

  // examine the current scan entry and fold it into the running hit/free results
  always_comb begin
    cur_hit      = tbl_valid[scan_idx] && (tbl_len[scan_idx] == lat_len) &&
                   (tbl_data[scan_idx] == lat_uid);
    cur_free     = !tbl_valid[scan_idx];
    fin_hit      = hit_found || cur_hit;
    fin_hit_idx  = hit_found ? hit_idx : scan_idx;
    fin_free     = free_found || cur_free;
    fin_free_idx = free_found ? free_idx : scan_idx;
    scan_last    = (scan_idx == IDXW'(UID_MAX - 1));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state, next output values and table write decisions
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready;
    rsp_valid_d  = rsp_valid;
    rsp_status_d = rsp_status;
    rsp_index_d  = rsp_index;
    uid_count_d  = uid_count;
    latch_en     = 1'b0;
    wr_add       = 1'b0;
    wr_rem       = 1'b0;
    wr_clr       = 1'b0;
    wr_idx       = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          latch_en    = 1'b1;
          req_ready_d = 1'b0;
          rsp_index_d = '0;
          if (req_cmd != CMD_CHECK && req_cmd != CMD_ADD &&
              req_cmd != CMD_REMOVE && req_cmd != CMD_CLEAR) begin
            rsp_status_d = ST_BAD_CMD;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
          end else if (req_cmd == CMD_CLEAR) begin
            wr_clr       = 1'b1;
            uid_count_d  = '0;
            rsp_status_d = ST_OK;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
          end else if (req_uid_len == '0 || req_uid_len > LENW'(UID_LEN_MAX)) begin
            rsp_status_d = ST_BAD_LEN;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (scan_last) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_index_d = '0;
          if (lat_cmd == CMD_ADD) begin
            if (fin_hit) begin
              rsp_status_d = ST_DUPLICATE;
              rsp_index_d  = fin_hit_idx;
            end else if (!fin_free) begin
              rsp_status_d = ST_FULL;
            end else begin
              wr_add       = 1'b1;
              wr_idx       = fin_free_idx;
              uid_count_d  = uid_count + CNTW'(1);
              rsp_status_d = ST_OK;
              rsp_index_d  = fin_free_idx;
            end
          end else if (fin_hit) begin
            if (lat_cmd == CMD_REMOVE) begin
              wr_rem      = 1'b1;
              wr_idx      = fin_hit_idx;
              uid_count_d = uid_count - CNTW'(1);
            end
            rsp_status_d = ST_OK;
            rsp_index_d  = fin_hit_idx;
          end else begin
            rsp_status_d = ST_NOT_FOUND;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // registered handshake, status and occupancy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_index  <= '0;
      uid_count  <= '0;
    end else begin
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_status <= rsp_status_d;
      rsp_index  <= rsp_index_d;
      uid_count  <= uid_count_d;
    end
  end

  // request latch and scan progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cmd    <= '0;
      lat_len    <= '0;
      lat_uid    <= '0;
      scan_idx   <= '0;
      hit_found  <= 1'b0;
      free_found <= 1'b0;
      hit_idx    <= '0;
      free_idx   <= '0;
    end else if (latch_en) begin
      lat_cmd    <= req_cmd;
      lat_len    <= req_uid_len;
      lat_uid    <= uid_masked;
      scan_idx   <= '0;
      hit_found  <= 1'b0;
      free_found <= 1'b0;
      hit_idx    <= '0;
      free_idx   <= '0;
    end else if (state_q == S_SCAN) begin
      scan_idx <= scan_idx + IDXW'(1);
      if (cur_hit && !hit_found) begin
        hit_found <= 1'b1;
        hit_idx   <= scan_idx;
      end
      if (cur_free && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= scan_idx;
      end
    end
  end

  // table contents: clear, add into a free slot, or drop a matched entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(UID_MAX); k++) begin
        tbl_valid[k] <= 1'b0;
        tbl_len[k]   <= '0;
        tbl_data[k]  <= '0;
      end
    end else if (wr_clr) begin
      for (int k = 0; k < int'(UID_MAX); k++) tbl_valid[k] <= 1'b0;
    end else if (wr_add) begin
      tbl_valid[wr_idx] <= 1'b1;
      tbl_len[wr_idx]   <= lat_len;
      tbl_data[wr_idx]  <= lat_uid;
    end else if (wr_rem) begin
      tbl_valid[wr_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_auth_table.sv
// Directed bench for auth_table with hand-computed responses and latencies.
module tb_auth_table;

  localparam int unsigned UID_MAX     = 8;
  localparam int unsigned UID_LEN_MAX = 10;
  localparam int unsigned IDXW        = $clog2(UID_MAX);
  localparam int unsigned CNTW        = $clog2(UID_MAX + 1);
  localparam int unsigned UIDW        = 8 * UID_LEN_MAX;

  localparam logic [7:0] C_CHECK  = 8'h10;
  localparam logic [7:0] C_ADD    = 8'h11;
  localparam logic [7:0] C_REMOVE = 8'h12;
  localparam logic [7:0] C_CLEAR  = 8'h13;

  localparam int OK = 0, NF = 1, DUP = 2, FULL = 3, BLEN = 4, BCMD = 5;
  localparam int SCAN_LAT = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [7:0]      req_cmd;
  logic [UIDW-1:0] req_uid;
  logic [7:0]      req_uid_len;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2:0]      rsp_status;
  logic [IDXW-1:0] rsp_index;
  logic [CNTW-1:0] uid_count;

  int checks = 0;
  int errors = 0;

  auth_table #(.UID_MAX(UID_MAX), .UID_LEN_MAX(UID_LEN_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_uid(req_uid), .req_uid_len(req_uid_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_index(rsp_index), .uid_count(uid_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // issue one request, measure edges from acceptance to rsp_valid, check, then consume
  task automatic do_req(input string tag, input logic [7:0] cmd, input logic [UIDW-1:0] uid,
                        input logic [7:0] len, input int exp_st, input int exp_idx,
                        input int exp_lat, input int exp_cnt);
    int n;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 1);
    req_valid = 1'b1; req_cmd = cmd; req_uid = uid; req_uid_len = len;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".status"}, 32'(rsp_status), exp_st);
    chk({tag, ".index"}, 32'(rsp_index), exp_idx);
    chk({tag, ".count"}, 32'(uid_count), exp_cnt);
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, ".rsp_drop"}, 32'(rsp_valid), 0);
  endtask

  function automatic logic [UIDW-1:0] uid4(input int i);
    return UIDW'(32'hC0DE_0000 + 32'(i));
  endfunction

  logic [UIDW-1:0] u7, u10, ua, ub;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_uid = '0; req_uid_len = '0;
    rsp_ready = 1'b0;
    u7  = 80'h0000_00F6_E5D4_C3B2_A104;
    u10 = 80'h0102_0304_0506_0708_090A;
    ua  = 80'h0000_0000_0000_1122_3344;
    ub  = 80'h0000_0000_0000_5566_7788;
    #12;
    chk("rst.req_ready", 32'(req_ready), 1);
    chk("rst.rsp_valid", 32'(rsp_valid), 0);
    chk("rst.rsp_status", 32'(rsp_status), 0);
    chk("rst.rsp_index", 32'(rsp_index), 0);
    chk("rst.uid_count", 32'(uid_count), 0);
    @(negedge clk) rst_n = 1'b1;

    do_req("chk_empty", C_CHECK, 80'hDEAD_BEEF, 8'd4, NF, 0, SCAN_LAT, 0);

    do_req("add_u7", C_ADD, u7, 8'd7, OK, 0, SCAN_LAT, 1);
    do_req("chk_u7", C_CHECK, u7, 8'd7, OK, 0, SCAN_LAT, 1);
    do_req("chk_u7_len4", C_CHECK, u7, 8'd4, NF, 0, SCAN_LAT, 1);

    do_req("clr0", C_CLEAR, '0, 8'd0, OK, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      do_req($sformatf("fill%0d", i), C_ADD, uid4(i), 8'd4, OK, i, SCAN_LAT, i + 1);
    do_req("add_full", C_ADD, uid4(8), 8'd4, FULL, 0, SCAN_LAT, 8);
    do_req("add_dup2", C_ADD, uid4(2), 8'd4, DUP, 2, SCAN_LAT, 8);

    do_req("rem3", C_REMOVE, uid4(3), 8'd4, OK, 3, SCAN_LAT, 7);
    do_req("add_hole", C_ADD, u10, 8'd10, OK, 3, SCAN_LAT, 8);
    do_req("chk_u10", C_CHECK, u10, 8'd10, OK, 3, SCAN_LAT, 8);
    do_req("chk_rem3", C_CHECK, uid4(3), 8'd4, NF, 0, SCAN_LAT, 8);
    do_req("rem_absent", C_REMOVE, uid4(9), 8'd4, NF, 0, SCAN_LAT, 8);

    do_req("len0", C_ADD, uid4(9), 8'd0, BLEN, 0, 0, 8);
    do_req("len11", C_CHECK, u10, 8'd11, BLEN, 0, 0, 8);
    do_req("badcmd", 8'h7F, uid4(1), 8'd4, BCMD, 0, 0, 8);
    do_req("clear", C_CLEAR, '0, 8'd0, OK, 0, 0, 0);
    do_req("chk_after_clr", C_CHECK, uid4(5), 8'd4, NF, 0, SCAN_LAT, 0);

    // backpressure with a request held pending
    do_req("add_ua", C_ADD, ua, 8'd4, OK, 0, SCAN_LAT, 1);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = C_CHECK; req_uid = ua; req_uid_len = 8'd4;
    @(posedge clk);
    begin
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
        @(posedge clk); #1; n++;
      end
      chk("hold.latency", n, SCAN_LAT);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d.rsp_valid", c), 32'(rsp_valid), 1);
      chk($sformatf("hold%0d.status", c), 32'(rsp_status), OK);
      chk($sformatf("hold%0d.index", c), 32'(rsp_index), 0);
      chk($sformatf("hold%0d.req_ready", c), 32'(req_ready), 0);
    end
    @(negedge clk) begin req_valid = 1'b0; rsp_ready = 1'b1; end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("hold.release", 32'(req_ready), 1);

    // reset in the middle of an ADD scan
    @(negedge clk);
    req_valid = 1'b1; req_cmd = C_ADD; req_uid = ub; req_uid_len = 8'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst.req_ready", 32'(req_ready), 1);
    chk("midrst.rsp_valid", 32'(rsp_valid), 0);
    chk("midrst.rsp_status", 32'(rsp_status), 0);
    chk("midrst.rsp_index", 32'(rsp_index), 0);
    chk("midrst.uid_count", 32'(uid_count), 0);
    @(negedge clk) rst_n = 1'b1;
    do_req("chk_ub_after_rst", C_CHECK, ub, 8'd4, NF, 0, SCAN_LAT, 0);
    do_req("add_ub_after_rst", C_ADD, ub, 8'd4, OK, 0, SCAN_LAT, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
